ctrl_fsm_param: RTL and testbench
=================================

CTRL_FSM_PARAM -- requirements
Module: ctrl_fsm_param

Interface
REQ-001 SHALL take parameter IW, default 16: instruction width; opcode is ins[IW-1:IW-4].
REQ-002 SHALL take parameter RW, default 2: register index width; rd = IR[IW-5 -: RW], rs = IR[IW-5-RW -: RW].
REQ-003 SHALL take parameter OFFW, default 8: offset width; offset = IR[OFFW-1:0].
REQ-004 SHALL provide these ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- en  in  1  run enable.
- ins  in  IW  instruction word.
- ins_valid  in  1  instruction present.
- ins_ready  out  1  controller accepts instruction.
- mem_ready  in  1  RAM access complete.
- zero  in  1  ALU zero flag.
- rd, rs  out  RW  decoded register indices.
- offset_addr  out  OFFW  decoded offset.
- en_fetch_pulse, en_pc_pulse, en_mar_pulse  out  1  one-cycle strobes.
- pc_ctrl  out  2  00 hold, 01 increment, 10 load offset.
- reg_en  out  2**RW  one-hot register write enable.
- alu_func  out  4  ALU operation.
- alu_in_sel  out  1  0 = rs, 1 = offset.
- en_ram, wen_ram  out  1  RAM enable and write enable.
- mdr_ctrl  out  2  00 idle, 01 load from RAM, 10 drive store.
- reg_in_sel  out  1  0 = ALU, 1 = MDR.
- state  out  3  current FSM state.
- illegal  out  1  sticky undefined-opcode flag.

Function
REQ-005 SHALL decode opcodes as follows: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 ADDI, 6 LOAD, 7 STORE, 8 JMP, 9 BEQZ, F HALT; A-E are illegal and execute as NOP with illegal set.
REQ-006 SHALL implement these states: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
REQ-007 In IDLE, the FSM SHALL go to FETCH when en=1, else stay in IDLE.
REQ-008 In FETCH, ins_ready SHALL be 1. On ins_valid&ins_ready the FSM SHALL latch IR, pulse en_fetch_pulse and go to DECODE. If en=0 and no handshake occurs, it SHALL go to IDLE.
REQ-009 rd, rs and offset_addr SHALL come from the latched IR, never from the live ins, and SHALL be stable from DECODE until the next latch.
REQ-010 DECODE SHALL last exactly one cycle and then go to EXEC.
REQ-011 In EXEC, ALU ops (1-5) SHALL drive alu_func = opcode and alu_in_sel = (op==ADDI), then go to WB.
REQ-012 In EXEC, LOAD and STORE SHALL pulse en_mar_pulse with alu_in_sel=1, then go to MEM.
REQ-013 In EXEC, JMP SHALL produce en_pc_pulse with pc_ctrl=10, then go to FETCH.
REQ-014 In EXEC, BEQZ SHALL produce en_pc_pulse with pc_ctrl=10 if zero=1, else 01, then go to FETCH.
REQ-015 In EXEC, NOP and illegal opcodes SHALL produce en_pc_pulse with pc_ctrl=01, then go to FETCH. HALT SHALL go to HALT.
REQ-016 In MEM, en_ram SHALL be 1 and wen_ram SHALL equal (op==STORE); mdr_ctrl SHALL be 01 for LOAD and 10 for STORE. The FSM SHALL hold in MEM until mem_ready=1; then LOAD goes to WB, and STORE pulses en_pc_pulse with pc_ctrl=01 and goes to FETCH.
REQ-017 In WB, reg_en SHALL be 1<<rd, reg_in_sel SHALL equal (op==LOAD), and en_pc_pulse SHALL fire with pc_ctrl=01; the FSM then goes to FETCH.
REQ-018 HALT SHALL be absorbing until reset, with all strobes at 0.
REQ-019 All outputs except illegal SHALL be combinational decode of the state register and IR only. No input-to-output combinational path is permitted other than the BEQZ zero path.
REQ-020 Every strobe SHALL be high for exactly one cycle per instruction.
REQ-021 Outside the states named above, every output SHALL be 0 (pc_ctrl=00, mdr_ctrl=00).
REQ-022 Every instruction SHALL take this many cycles, ignoring stalls: ALU 4 (FETCH, DECODE, EXEC, WB); LOAD 5; STORE 4; JMP, BEQZ and NOP 3.
REQ-023 en is sampled only in IDLE and FETCH; an instruction in flight SHALL always complete.

Reset
REQ-024 On rst=0, the block SHALL asynchronously force: state=IDLE, IR=0, illegal=0, and all strobes, enables and select outputs to 0.
REQ-025 Reset asserted in MEM SHALL drop en_ram and wen_ram in the same cycle, with no partial write strobe after release.
REQ-026 After rst rises, the first transition SHALL occur on the next clk edge with en=1.

Structure
REQ-027 Opcode localparams, state encodings and pc_ctrl/mdr_ctrl codes SHALL live in shared package ctrl_pkg.
REQ-028 The IR latch SHALL be a sub-module, ir_reg, parametrised by IW, with load enable and asynchronous active-low reset.

Verification
REQ-029 Reset, then en=1, ins=16'h1600 (ADD rd=1, rs=2), ins_valid=1 -> states 1,2,3,5; reg_en=4'b0010 in WB; en_pc_pulse with pc_ctrl=01.
REQ-030 LOAD 16'h6C05 with mem_ready low for 3 cycles -> en_ram held 4 cycles, wen_ram=0, then WB with reg_en=4'b1000 and reg_in_sel=1.
REQ-031 BEQZ 16'h9010 with zero=1 -> pc_ctrl=10, offset_addr=8'h10; repeat with zero=0 -> pc_ctrl=01.
REQ-032 ins=16'hB000 -> illegal=1 and stays 1 after the next NOP; PC increments.
REQ-033 rst=0 mid-MEM of STORE 16'h7400 -> en_ram and wen_ram drop to 0 immediately; state=IDLE.
REQ-034 en=0 in FETCH with ins_valid=0 -> IDLE; HALT 16'hF000 -> state=6 held for 20 cycles, all strobes 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared opcodes, FSM state encoding and datapath control codes for the
// multi-cycle instruction controller.
package ctrl_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_LOAD  = 4'h6;
  localparam logic [3:0] OP_STORE = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_BEQZ  = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;

  localparam logic [1:0] MDR_IDLE  = 2'b00;
  localparam logic [1:0] MDR_LOAD  = 2'b01;
  localparam logic [1:0] MDR_STORE = 2'b10;

  function automatic logic is_alu(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_ADDI);
  endfunction

  // Opcodes A..E are undefined; they run as NOP and raise the sticky flag.
  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/ctrl_fsm_param_if.sv
// Controller <-> datapath/instruction-source bundle. The master side is the
// controller; the slave side is whatever feeds it instructions and status.
interface ctrl_fsm_param_if #(
  parameter int IW   = 16,
  parameter int RW   = 2,
  parameter int OFFW = 8
);
  logic               en;
  logic [IW-1:0]      ins;
  logic               ins_valid;
  logic               ins_ready;
  logic               mem_ready;
  logic               zero;
  logic [RW-1:0]      rd;
  logic [RW-1:0]      rs;
  logic [OFFW-1:0]    offset_addr;
  logic               en_fetch_pulse;
  logic               en_pc_pulse;
  logic               en_mar_pulse;
  logic [1:0]         pc_ctrl;
  logic [(2**RW)-1:0] reg_en;
  logic [3:0]         alu_func;
  logic               alu_in_sel;
  logic               en_ram;
  logic               wen_ram;
  logic [1:0]         mdr_ctrl;
  logic               reg_in_sel;
  logic [2:0]         state;
  logic               illegal;

  modport master (
    input  en, ins, ins_valid, mem_ready, zero,
    output ins_ready, rd, rs, offset_addr, en_fetch_pulse, en_pc_pulse,
           en_mar_pulse, pc_ctrl, reg_en, alu_func, alu_in_sel, en_ram,
           wen_ram, mdr_ctrl, reg_in_sel, state, illegal
  );

  modport slave (
    output en, ins, ins_valid, mem_ready, zero,
    input  ins_ready, rd, rs, offset_addr, en_fetch_pulse, en_pc_pulse,
           en_mar_pulse, pc_ctrl, reg_en, alu_func, alu_in_sel, en_ram,
           wen_ram, mdr_ctrl, reg_in_sel, state, illegal
  );
endinterface

// File: rtl/ir_reg.sv
// Instruction register: captures the instruction word on load, cleared by reset.
module ir_reg #(
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [IW-1:0] d,
  output logic [IW-1:0] q
);

  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/ctrl_fsm_param.sv
// Multi-cycle instruction controller: fetch/decode/execute/memory/writeback
// FSM. Outputs decode from the state register and the latched IR.
module ctrl_fsm_param
  import ctrl_pkg::*;
#(
  parameter int IW   = 16,
  parameter int RW   = 2,
  parameter int OFFW = 8
) (
  input  logic              clk,
  input  logic              rst,
  ctrl_fsm_param_if.master  bus
);

  state_t        state_q, state_d;
  logic [IW-1:0] ir;
  logic [3:0]    op;
  logic          ir_load;
  logic          illegal_q;

  assign op      = ir[IW-1 -: 4];
  assign ir_load = (state_q == S_FETCH) && bus.ins_valid;

  ir_reg #(.IW(IW)) u_ir_reg (
    .clk  (clk),
    .rst  (rst),
    .load (ir_load),
    .d    (bus.ins),
    .q    (ir)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | ((state_q == S_DECODE) && is_illegal(op));
    end
  end

  // Register fields come only from the latched IR, so they stay put while
  // the source presents the next word.
  assign bus.rd          = ir[IW-5 -: RW];
  assign bus.rs          = ir[IW-5-RW -: RW];
  assign bus.offset_addr = ir[OFFW-1:0];
  assign bus.state       = state_q;
  assign bus.illegal     = illegal_q;

  // NOTE: every signal driven here gets a default first; any path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    state_d            = state_q;
    bus.ins_ready      = 1'b0;
    bus.en_fetch_pulse = 1'b0;
    bus.en_pc_pulse    = 1'b0;
    bus.en_mar_pulse   = 1'b0;
    bus.pc_ctrl        = PC_HOLD;
    bus.reg_en         = '0;
    bus.alu_func       = 4'h0;
    bus.alu_in_sel     = 1'b0;
    bus.en_ram         = 1'b0;
    bus.wen_ram        = 1'b0;
    bus.mdr_ctrl       = MDR_IDLE;
    bus.reg_in_sel     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.en) state_d = S_FETCH;
      end

      S_FETCH: begin
        bus.ins_ready = 1'b1;
        if (bus.ins_valid) state_d = S_DECODE;
        else if (!bus.en)  state_d = S_IDLE;
      end

      // The fetch strobe marks the first cycle the new IR is visible.
      S_DECODE: begin
        bus.en_fetch_pulse = 1'b1;
        state_d            = S_EXEC;
      end

      S_EXEC: begin
        if (is_alu(op)) begin
          bus.alu_func   = op;
          bus.alu_in_sel = (op == OP_ADDI);
          state_d        = S_WB;
        end else if ((op == OP_LOAD) || (op == OP_STORE)) begin
          bus.en_mar_pulse = 1'b1;
          bus.alu_in_sel   = 1'b1;
          state_d          = S_MEM;
        end else if (op == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          bus.en_pc_pulse = 1'b1;
          if (op == OP_JMP)                  bus.pc_ctrl = PC_LOAD;
          else if (op == OP_BEQZ && bus.zero) bus.pc_ctrl = PC_LOAD;
          else                               bus.pc_ctrl = PC_INC;
          state_d = S_FETCH;
        end
      end

      S_MEM: begin
        bus.en_ram   = 1'b1;
        bus.wen_ram  = (op == OP_STORE);
        bus.mdr_ctrl = (op == OP_STORE) ? MDR_STORE : MDR_LOAD;
        if (bus.mem_ready) begin
          if (op == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            // A store retires in its final MEM cycle; stalls must not repeat the PC strobe.
            bus.en_pc_pulse = 1'b1;
            bus.pc_ctrl     = PC_INC;
            state_d         = S_FETCH;
          end
        end
      end

      S_WB: begin
        bus.reg_en[bus.rd] = 1'b1;
        bus.reg_in_sel     = (op == OP_LOAD);
        bus.en_pc_pulse    = 1'b1;
        bus.pc_ctrl        = PC_INC;
        state_d            = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ctrl_fsm_param.sv
// Directed bench for ctrl_fsm_param: ALU, LOAD/STORE with stalls, branches,
// illegal opcodes, reset during MEM, en drop in FETCH and HALT.
module tb_ctrl_fsm_param;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  ctrl_fsm_param_if #(.IW(16), .RW(2), .OFFW(8)) bus ();

  ctrl_fsm_param #(.IW(16), .RW(2), .OFFW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction in FETCH, then withdraws it with junk on ins.
  task automatic do_fetch(input logic [15:0] w);
    bus.ins       = w;
    bus.ins_valid = 1'b1;
    step();
    bus.ins_valid = 1'b0;
    bus.ins       = 16'hFFFF;
    check("fetch_to_decode", 32'(bus.state), 32'(S_DECODE));
    check("fetch_pulse", 32'(bus.en_fetch_pulse), 32'd1);
  endtask

  function automatic logic [31:0] strobes();
    return 32'({bus.en_fetch_pulse, bus.en_pc_pulse, bus.en_mar_pulse, bus.en_ram,
                bus.wen_ram, bus.reg_en, bus.pc_ctrl, bus.mdr_ctrl, bus.ins_ready});
  endfunction

  initial begin
    bus.en        = 1'b0;
    bus.ins       = 16'h0000;
    bus.ins_valid = 1'b0;
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;

    // Reset state
    #12;
    check("rst_state", 32'(bus.state), 32'(S_IDLE));
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    check("rst_strobes", strobes(), 32'd0);
    rst = 1'b1;

    // ADD rd=1 rs=2
    bus.en = 1'b1;
    bus.ins = 16'h1600;
    bus.ins_valid = 1'b1;
    step();
    check("add_fetch", 32'(bus.state), 32'(S_FETCH));
    check("add_ins_ready", 32'(bus.ins_ready), 32'd1);
    step();
    bus.ins_valid = 1'b0;
    bus.ins = 16'hFFFF;
    check("add_decode", 32'(bus.state), 32'(S_DECODE));
    check("add_rd", 32'(bus.rd), 32'd1);
    check("add_rs", 32'(bus.rs), 32'd2);
    step();
    check("add_exec", 32'(bus.state), 32'(S_EXEC));
    check("add_alu_func", 32'(bus.alu_func), 32'd1);
    check("add_alu_in_sel", 32'(bus.alu_in_sel), 32'd0);
    check("add_rd_stable", 32'(bus.rd), 32'd1);
    step();
    check("add_wb", 32'(bus.state), 32'(S_WB));
    check("add_reg_en", 32'(bus.reg_en), 32'b0010);
    check("add_pc_pulse", 32'(bus.en_pc_pulse), 32'd1);
    check("add_pc_ctrl", 32'(bus.pc_ctrl), 32'b01);
    check("add_reg_in_sel", 32'(bus.reg_in_sel), 32'd0);
    step();
    check("add_back_fetch", 32'(bus.state), 32'(S_FETCH));

    // LOAD rd=3 offset 5, three stall cycles
    do_fetch(16'h6C05);
    check("ld_rd", 32'(bus.rd), 32'd3);
    check("ld_offset", 32'(bus.offset_addr), 32'h05);
    step();
    check("ld_exec_mar", 32'(bus.en_mar_pulse), 32'd1);
    check("ld_exec_sel", 32'(bus.alu_in_sel), 32'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      check("ld_stall_state", 32'(bus.state), 32'(S_MEM));
      check("ld_stall_en_ram", 32'(bus.en_ram), 32'd1);
      check("ld_stall_wen", 32'(bus.wen_ram), 32'd0);
      check("ld_stall_mdr", 32'(bus.mdr_ctrl), 32'b01);
      step();
    end
    bus.mem_ready = 1'b1;
    #1;
    check("ld_mem_last_state", 32'(bus.state), 32'(S_MEM));
    check("ld_mem_last_en_ram", 32'(bus.en_ram), 32'd1);
    check("ld_mem_no_pc", 32'(bus.en_pc_pulse), 32'd0);
    step();
    bus.mem_ready = 1'b0;
    check("ld_wb", 32'(bus.state), 32'(S_WB));
    check("ld_reg_en", 32'(bus.reg_en), 32'b1000);
    check("ld_reg_in_sel", 32'(bus.reg_in_sel), 32'd1);
    check("ld_wb_en_ram", 32'(bus.en_ram), 32'd0);
    step();

    // BEQZ taken, then not taken
    do_fetch(16'h9010);
    check("beqz_offset", 32'(bus.offset_addr), 32'h10);
    bus.zero = 1'b1;
    step();
    check("beqz_t_pulse", 32'(bus.en_pc_pulse), 32'd1);
    check("beqz_t_pc_ctrl", 32'(bus.pc_ctrl), 32'b10);
    step();
    check("beqz_t_back", 32'(bus.state), 32'(S_FETCH));
    do_fetch(16'h9010);
    bus.zero = 1'b0;
    step();
    check("beqz_nt_pc_ctrl", 32'(bus.pc_ctrl), 32'b01);
    step();

    // JMP
    do_fetch(16'h8020);
    step();
    check("jmp_pc_ctrl", 32'(bus.pc_ctrl), 32'b10);
    step();

    // Illegal opcode, then NOP
    do_fetch(16'hB000);
    check("ill_not_yet", 32'(bus.illegal), 32'd0);
    step();
    check("ill_set", 32'(bus.illegal), 32'd1);
    check("ill_pc_ctrl", 32'(bus.pc_ctrl), 32'b01);
    check("ill_pc_pulse", 32'(bus.en_pc_pulse), 32'd1);
    step();
    do_fetch(16'h0000);
    step();
    check("nop_pc_ctrl", 32'(bus.pc_ctrl), 32'b01);
    step();
    check("ill_sticky", 32'(bus.illegal), 32'd1);

    // STORE completing with no stall
    do_fetch(16'h7400);
    step();
    check("st_exec_mar", 32'(bus.en_mar_pulse), 32'd1);
    bus.mem_ready = 1'b1;
    step();
    check("st_mem_en_ram", 32'(bus.en_ram), 32'd1);
    check("st_mem_wen", 32'(bus.wen_ram), 32'd1);
    check("st_mem_mdr", 32'(bus.mdr_ctrl), 32'b10);
    check("st_pc_pulse", 32'(bus.en_pc_pulse), 32'd1);
    check("st_pc_ctrl", 32'(bus.pc_ctrl), 32'b01);
    step();
    bus.mem_ready = 1'b0;
    check("st_back_fetch", 32'(bus.state), 32'(S_FETCH));

    // STORE interrupted by reset during MEM
    do_fetch(16'h7400);
    step();
    step();
    check("st_stall_wen", 32'(bus.wen_ram), 32'd1);
    check("st_stall_no_pc", 32'(bus.en_pc_pulse), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mem_en_ram", 32'(bus.en_ram), 32'd0);
    check("rst_mem_wen", 32'(bus.wen_ram), 32'd0);
    check("rst_mem_state", 32'(bus.state), 32'(S_IDLE));
    check("rst_mem_illegal", 32'(bus.illegal), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rel_state", 32'(bus.state), 32'(S_IDLE));
    check("rel_ir_clear", 32'(bus.rd), 32'd0);
    step();
    check("rel_first_edge", 32'(bus.state), 32'(S_FETCH));
    check("rel_no_write", 32'(bus.wen_ram), 32'd0);

    // en dropped in FETCH with no instruction
    bus.en = 1'b0;
    step();
    check("en_drop_idle", 32'(bus.state), 32'(S_IDLE));
    step();
    check("en_low_stays", 32'(bus.state), 32'(S_IDLE));
    bus.en = 1'b1;
    step();
    check("en_back_fetch", 32'(bus.state), 32'(S_FETCH));

    // HALT is absorbing
    do_fetch(16'hF000);
    step();
    step();
    bus.ins_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("halt_state", 32'(bus.state), 32'(S_HALT));
      check("halt_strobes", strobes(), 32'd0);
      step();
    end
    bus.ins_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
